// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared opcode/funct3 encodings and the resolve-register payload used by
// the branch redirect controller and its condition comparator.
package branch_redirect_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned FNC_W = 3;

  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  localparam logic [FNC_W-1:0] FNC_BEQ  = 3'b000;
  localparam logic [FNC_W-1:0] FNC_BNE  = 3'b001;
  localparam logic [FNC_W-1:0] FNC_BLT  = 3'b100;
  localparam logic [FNC_W-1:0] FNC_BGE  = 3'b101;
  localparam logic [FNC_W-1:0] FNC_BLTU = 3'b110;
  localparam logic [FNC_W-1:0] FNC_BGEU = 3'b111;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [FNC_W-1:0] funct3;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic             pred_taken;
  } resolve_t;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage offer, pipeline control, fetch redirect and statistics bundle.
interface branch_redirect_ctrl_if
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);

  logic             br_valid;
  logic             br_ready;
  logic [OPC_W-1:0] opcode;
  logic [FNC_W-1:0] funct3;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic             pred_taken;
  logic             flush;
  logic             stall;
  logic             redir_valid;
  logic [XLEN-1:0]  redir_pc;
  logic             redir_ready;
  logic [CNT_W-1:0] n_branch;
  logic [CNT_W-1:0] n_mispred;

  modport master (
    output br_valid, opcode, funct3, rs1_val, rs2_val, pc, imm, pred_taken, redir_ready,
    input  br_ready, flush, stall, redir_valid, redir_pc, n_branch, n_mispred
  );

  modport slave (
    input  br_valid, opcode, funct3, rs1_val, rs2_val, pc, imm, pred_taken, redir_ready,
    output br_ready, flush, stall, redir_valid, redir_pc, n_branch, n_mispred
  );

endinterface

// File: rtl/branch_redirect_ctrl_branch_cmp.sv
// Combinational branch condition evaluator; non-branch opcodes and
// undefined funct3 codes resolve as not taken.
module branch_cmp
  import branch_redirect_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  input  logic [FNC_W-1:0] funct3_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  output logic             taken_o
);

  always_comb begin
    taken_o = 1'b0;
    if (opcode_i == OPC_BRANCH) begin
      case (funct3_i)
        FNC_BEQ:  taken_o = (a_i == b_i);
        FNC_BNE:  taken_o = (a_i != b_i);
        FNC_BLT:  taken_o = ($signed(a_i) <  $signed(b_i));
        FNC_BGE:  taken_o = ($signed(a_i) >= $signed(b_i));
        FNC_BLTU: taken_o = (a_i <  b_i);
        FNC_BGEU: taken_o = (a_i >= b_i);
        default:  taken_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves EX-stage branches one cycle after capture and, on a mispredict,
// flushes younger stages then hands the corrected PC to fetch.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  branch_redirect_ctrl_if.slave  bus
);

  localparam int unsigned FC_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESOLVE,
    ST_FLUSH,
    ST_REDIRECT
  } state_e;

  state_e           state_q;
  resolve_t         res_q;
  logic [FC_W-1:0]  fcnt_q;
  logic             br_ready_q;
  logic             flush_q;
  logic             stall_q;
  logic             redir_valid_q;
  logic [XLEN-1:0]  redir_pc_q;
  logic [CNT_W-1:0] n_branch_q;
  logic [CNT_W-1:0] n_mispred_q;

  logic             taken_c;
  logic             is_branch_c;
  logic             mispred_c;
  logic [XLEN-1:0]  target_c;

  branch_cmp u_cmp (
    .opcode_i (res_q.opcode),
    .funct3_i (res_q.funct3),
    .a_i      (res_q.rs1_val),
    .b_i      (res_q.rs2_val),
    .taken_o  (taken_c)
  );

  // Resolution looks only at the captured instruction, never the live bus.
  assign is_branch_c = (res_q.opcode == OPC_BRANCH);
  assign mispred_c   = is_branch_c && (taken_c != res_q.pred_taken);
  assign target_c    = taken_c ? (res_q.pc + res_q.imm) : (res_q.pc + XLEN'(4));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      res_q         <= '0;
      fcnt_q        <= '0;
      br_ready_q    <= 1'b1;
      flush_q       <= 1'b0;
      stall_q       <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      n_branch_q    <= '0;
      n_mispred_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.br_valid) begin
            res_q      <= '{opcode:     bus.opcode,
                            funct3:     bus.funct3,
                            rs1_val:    bus.rs1_val,
                            rs2_val:    bus.rs2_val,
                            pc:         bus.pc,
                            imm:        bus.imm,
                            pred_taken: bus.pred_taken};
            state_q    <= ST_RESOLVE;
            br_ready_q <= 1'b0;
            stall_q    <= 1'b1;
          end
        end
        ST_RESOLVE: begin
          if (is_branch_c && (n_branch_q != '1)) begin
            n_branch_q <= n_branch_q + CNT_W'(1);
          end
          if (mispred_c) begin
            if (n_mispred_q != '1) begin
              n_mispred_q <= n_mispred_q + CNT_W'(1);
            end
            state_q    <= ST_FLUSH;
            flush_q    <= 1'b1;
            fcnt_q     <= FC_W'(FLUSH_CYCLES - 1);
            redir_pc_q <= target_c;
          end else begin
            state_q    <= ST_IDLE;
            br_ready_q <= 1'b1;
            stall_q    <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (fcnt_q == '0) begin
            state_q       <= ST_REDIRECT;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b1;
          end else begin
            fcnt_q <= fcnt_q - FC_W'(1);
          end
        end
        ST_REDIRECT: begin
          if (bus.redir_ready) begin
            state_q       <= ST_IDLE;
            redir_valid_q <= 1'b0;
            br_ready_q    <= 1'b1;
            stall_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.br_ready    = br_ready_q;
  assign bus.flush       = flush_q;
  assign bus.stall       = stall_q;
  assign bus.redir_valid = redir_valid_q;
  assign bus.redir_pc    = redir_pc_q;
  assign bus.n_branch    = n_branch_q;
  assign bus.n_mispred   = n_mispred_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench: directed and randomized branches against a
// rule-level model of condition, target, mispredict and handshake timing.
module tb_branch_redirect_ctrl;
  import branch_redirect_ctrl_pkg::*;

  localparam int FC = 2;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   exp_nb;
  int   exp_nm;

  branch_redirect_ctrl_if #(.CNT_W(32)) bus  ();
  branch_redirect_ctrl_if #(.CNT_W(2))  bus2 ();

  branch_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  branch_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference rules for branch outcome, written with integer arithmetic.
  function automatic bit model_taken(input logic [6:0] op, input logic [2:0] f,
                                     input logic [31:0] a, input logic [31:0] b);
    int     sa, sb;
    longint ua, ub;
    sa = int'(a);
    sb = int'(b);
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (op != 7'h63) return 1'b0;
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return ua < ub;
      3'd7:    return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_branch(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] p, input logic [31:0] im,
                           input logic pred, input int rdly);
    bit          tk, mp;
    logic [31:0] tgt;
    tk  = model_taken(op, f3, a, b);
    mp  = (op == 7'h63) && (tk != pred);
    tgt = tk ? p + im : p + 32'd4;

    checks++;
    if (bus.br_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b want 1", tag, bus.br_ready);
    end
    bus.br_valid = 1'b1; bus.opcode = op; bus.funct3 = f3;
    bus.rs1_val = a; bus.rs2_val = b; bus.pc = p; bus.imm = im;
    bus.pred_taken = pred; bus.redir_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    bus.br_valid = 1'b0;
    bus.rs1_val = $urandom; bus.rs2_val = $urandom; bus.pc = $urandom;
    bus.imm = $urandom; bus.pred_taken = 1'($urandom_range(0, 1));
    if (op == 7'h63) exp_nb++;
    if (mp) exp_nm++;

    checks++;
    if ({bus.stall, bus.br_ready, bus.flush, bus.redir_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL %s resolve_ctl: got %b want 1000", tag,
               {bus.stall, bus.br_ready, bus.flush, bus.redir_valid});
    end
    @(posedge clk); #1;

    if (!mp) begin
      checks++;
      if ({bus.stall, bus.br_ready, bus.flush, bus.redir_valid} !== 4'b0100) begin
        errors++;
        $display("FAIL %s no_mispred_idle: got %b want 0100", tag,
                 {bus.stall, bus.br_ready, bus.flush, bus.redir_valid});
      end
    end else begin
      for (int i = 0; i < FC; i++) begin
        checks++;
        if ({bus.stall, bus.br_ready, bus.flush, bus.redir_valid} !== 4'b1010) begin
          errors++;
          $display("FAIL %s flush_cycle%0d: got %b want 1010", tag, i,
                   {bus.stall, bus.br_ready, bus.flush, bus.redir_valid});
        end
        bus.redir_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      for (int i = 0; i <= rdly; i++) begin
        bus.redir_ready = (i == rdly);
        checks++;
        if ({bus.stall, bus.br_ready, bus.flush, bus.redir_valid} !== 4'b1001 ||
            bus.redir_pc !== tgt) begin
          errors++;
          $display("FAIL %s redirect_hold%0d: ctl %b pc %h want 1001 pc %h", tag, i,
                   {bus.stall, bus.br_ready, bus.flush, bus.redir_valid}, bus.redir_pc, tgt);
        end
        @(posedge clk); #1;
      end
      bus.redir_ready = 1'b0;
      checks++;
      if ({bus.stall, bus.br_ready, bus.flush, bus.redir_valid} !== 4'b0100) begin
        errors++;
        $display("FAIL %s after_handshake: got %b want 0100", tag,
                 {bus.stall, bus.br_ready, bus.flush, bus.redir_valid});
      end
    end

    checks++;
    if (bus.n_branch !== 32'(exp_nb) || bus.n_mispred !== 32'(exp_nm)) begin
      errors++;
      $display("FAIL %s counters: got %0d/%0d want %0d/%0d", tag,
               bus.n_branch, bus.n_mispred, exp_nb, exp_nm);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.br_valid = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.rs1_val = '0;
    bus.rs2_val = '0; bus.pc = '0; bus.imm = '0; bus.pred_taken = 1'b0;
    bus.redir_ready = 1'b0;
    bus2.br_valid = 1'b0; bus2.opcode = '0; bus2.funct3 = '0; bus2.rs1_val = '0;
    bus2.rs2_val = '0; bus2.pc = '0; bus2.imm = '0; bus2.pred_taken = 1'b0;
    bus2.redir_ready = 1'b0;
    exp_nb = 0; exp_nm = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.stall, bus.flush, bus.redir_valid} !== 3'b000 || bus.redir_pc !== 32'h0 ||
        bus.n_branch !== 32'h0 || bus.n_mispred !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ctl %b pc %h cnt %0d/%0d want 000 0 0/0",
               {bus.stall, bus.flush, bus.redir_valid}, bus.redir_pc,
               bus.n_branch, bus.n_mispred);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.br_ready !== 1'b1 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready %b stall %b want 1 0", bus.br_ready, bus.stall);
    end
  endtask

  task automatic test_directed();
    do_branch("beq_mispred", OPC_BRANCH, FNC_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 0);
    do_branch("blt_signed",  OPC_BRANCH, FNC_BLT, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b1, 0);
    do_branch("bltu_unsig",  OPC_BRANCH, FNC_BLTU, 32'hFFFFFFFF, 32'd1, 32'h300, 32'h40, 1'b1, 1);
    do_branch("non_branch",  7'h33, 3'd0, 32'd1, 32'd1, 32'h400, 32'h8, 1'b1, 0);
    do_branch("undef_f3",    OPC_BRANCH, 3'd2, 32'd1, 32'd1, 32'h500, 32'h8, 1'b1, 0);
    do_branch("pc_wrap",     OPC_BRANCH, FNC_BNE, 32'd7, 32'd7, 32'hFFFFFFFC, 32'h10, 1'b1, 0);
    do_branch("tgt_wrap",    OPC_BRANCH, FNC_BGEU, 32'd9, 32'd3, 32'hFFFFFFF0, 32'h20, 1'b0, 0);
  endtask

  task automatic test_redirect_hold();
    do_branch("ready_low5", OPC_BRANCH, FNC_BGE, 32'd3, 32'hFFFFFFFE, 32'h600, 32'hFFFFFF00, 1'b0, 5);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      logic [6:0]  op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 3) == 0) ? 7'($urandom) : OPC_BRANCH;
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
      do_branch("random", op, 3'($urandom), a, b, $urandom, $urandom,
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
  endtask

  task automatic test_mid_flush_reset();
    bus.br_valid = 1'b1; bus.opcode = OPC_BRANCH; bus.funct3 = FNC_BEQ;
    bus.rs1_val = 32'd5; bus.rs2_val = 32'd5; bus.pc = 32'h100; bus.imm = 32'h20;
    bus.pred_taken = 1'b0; bus.redir_ready = 1'b1;
    @(posedge clk); #1;
    bus.br_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.flush !== 1'b1) begin
      errors++;
      $display("FAIL midflush_second_cycle: flush %b want 1", bus.flush);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    exp_nb = 0; exp_nm = 0;
    checks++;
    if ({bus.flush, bus.redir_valid, bus.stall, bus.br_ready} !== 4'b0001 ||
        bus.n_branch !== 32'h0 || bus.n_mispred !== 32'h0) begin
      errors++;
      $display("FAIL midflush_reset: ctl %b cnt %0d/%0d want 0001 0/0",
               {bus.flush, bus.redir_valid, bus.stall, bus.br_ready},
               bus.n_branch, bus.n_mispred);
    end
    reset_n = 1'b1;
    bus.redir_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.flush, bus.redir_valid, bus.stall, bus.br_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL midflush_release: ctl %b want 0001",
               {bus.flush, bus.redir_valid, bus.stall, bus.br_ready});
    end
    do_branch("post_reset", OPC_BRANCH, FNC_BNE, 32'd1, 32'd2, 32'h700, 32'h4, 1'b0, 0);
  endtask

  task automatic test_saturation();
    int k;
    int want;
    k = 0;
    bus2.opcode = OPC_BRANCH; bus2.funct3 = FNC_BEQ; bus2.rs1_val = 32'd1;
    bus2.rs2_val = 32'd2; bus2.pc = 32'hFFFFFFFC; bus2.imm = 32'h8;
    bus2.pred_taken = 1'b1; bus2.redir_ready = 1'b1; bus2.br_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus2.redir_valid === 1'b1) begin
        k++;
        want = (k > 3) ? 3 : k;
        checks++;
        if (bus2.redir_pc !== 32'h0 || bus2.n_mispred !== 2'(want) ||
            bus2.n_branch !== 2'(want)) begin
          errors++;
          $display("FAIL sat_redirect%0d: pc %h cnt %0d/%0d want 0 %0d/%0d", k,
                   bus2.redir_pc, bus2.n_branch, bus2.n_mispred, want, want);
        end
      end
    end
    bus2.br_valid = 1'b0;
    checks++;
    if (k < 5) begin
      errors++;
      $display("FAIL sat_redirect_count: got %0d want >= 5", k);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_redirect_hold();
    test_back_to_back();
    test_mid_flush_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
